// File: rtl/temporal_window_controller.sv
// temporal_window_controller: sequencing FSM between the spatial encoder and the
// temporal encoder/accumulator pair. It owns every window boundary decision and
// carries no hypervector data.
// Optional feature macro: TEMPORAL_OVERLAP_EN. When it is defined, windows share
// n-gram history and skip the refill after a result is taken.
module temporal_window_controller #(
    parameter int unsigned WINDOW_SIZE = 5,
    parameter int unsigned NGRAM_SIZE  = 2,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 Clk_CI,
    input  logic                 Reset_RI,
    input  logic                 ValidIn_SI,
    output logic                 ReadyOut_SO,
    input  logic                 AccumDone_SI,
    input  logic                 ReadyIn_SI,
    output logic                 ValidOut_SO,
    output logic                 Shift_SO,
    output logic                 NewAccum_SO,
    output logic                 Bundle_SO,
    output logic                 Last_SO,
    output logic [CNT_WIDTH-1:0] NgramCount_DO,
    output logic                 Overrun_SO
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_ACCUM    = 3'd2;
    localparam logic [2:0] S_WAIT_ACC = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [CNT_WIDTH-1:0] WIN_MAX  = CNT_WIDTH'(WINDOW_SIZE);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WINDOW_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] FILL_MAX = CNT_WIDTH'(NGRAM_SIZE - 1);
    // With one sample per n-gram there is nothing to prime: every sample is an n-gram.
    localparam bit NGRAM_ONE = (NGRAM_SIZE == 1);

`ifdef TEMPORAL_OVERLAP_EN
    localparam logic [2:0] S_RESTART = S_ACCUM;
`else
    localparam logic [2:0] S_RESTART = NGRAM_ONE ? S_ACCUM : S_FILL;
`endif

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] fill_q, fill_d;
    logic [CNT_WIDTH-1:0] fill_inc;
    logic                 overrun_q;
    logic                 ready;
    logic                 accept;
    logic                 accum_phase;
    logic                 new_accum;
    logic                 bundle;
    logic                 last;

    assign fill_inc = fill_q + CNT_WIDTH'(1);

    // Next-state, counter updates and Mealy strobes from state and sample valid.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        fill_d      = fill_q;
        ready       = 1'b0;
        accum_phase = 1'b0;
        new_accum   = 1'b0;
        bundle      = 1'b0;
        last        = 1'b0;

        case (state_q)
            S_IDLE:  begin ready = 1'b1; accum_phase = NGRAM_ONE; end
            S_FILL:  ready = 1'b1;
            S_ACCUM: begin ready = 1'b1; accum_phase = 1'b1; end
            default: ;
        endcase

        accept = ValidIn_SI & ready;

        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept && !accum_phase) begin
                    fill_d  = fill_inc;
                    state_d = (fill_inc >= FILL_MAX) ? S_ACCUM : S_FILL;
                end
            end
            S_WAIT_ACC: begin
                if (AccumDone_SI) state_d = S_DONE;
            end
            S_DONE: begin
                if (ReadyIn_SI) begin
                    count_d = '0;
                    fill_d  = '0;
                    state_d = S_RESTART;
                end
            end
            default: ;
        endcase

        if (accept && accum_phase) begin
            new_accum = (count_q == '0);
            bundle    = !new_accum;
            last      = (count_q == LAST_IDX);
            if (count_q < WIN_MAX) count_d = count_q + CNT_WIDTH'(1);
            state_d   = last ? S_WAIT_ACC : S_ACCUM;
        end
    end

    // State register; reset aborts any window in progress.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // N-gram count, fill count and sticky overrun flag.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            count_q   <= '0;
            fill_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            fill_q    <= fill_d;
            overrun_q <= overrun_q | (ValidIn_SI & ~ready);
        end
    end

    assign ReadyOut_SO   = ready;
    assign ValidOut_SO   = (state_q == S_DONE);
    assign Shift_SO      = accept;
    assign NewAccum_SO   = new_accum;
    assign Bundle_SO     = bundle;
    assign Last_SO       = last;
    assign NgramCount_DO = count_q;
    assign Overrun_SO    = overrun_q;

endmodule
